// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bus of the shared byte-wide data memory: two ports (0 = MA stage, 1 = debug/loader).
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [2:0]        op_i    [2];
    logic [ADDR_W-1:0] addr_i  [2];
    logic [31:0]       wdata_i [2];
    logic [1:0]        gnt_o;
    logic [1:0]        done_o;
    logic [31:0]       rdata_o [2];
    logic [1:0]        err_o;

    modport master (
        output req_i, we_i, op_i, addr_i, wdata_i,
        input  gnt_o, done_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, op_i, addr_i, wdata_i,
        output gnt_o, done_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter for two requesters sharing a byte-wide single-port dmem; multi-byte
// accesses are sequenced one byte per cycle and loads are assembled little-endian.
module dmem_port_arbiter #(
    parameter int unsigned MEM_DEPTH = 1000,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [7:0]          mem_wdata_o,
    input  logic [7:0]          mem_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic [1:0]        gnt;
    logic              gnt_port;
    logic              sel_we;
    logic [2:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_n;
    logic [2:0]        lat_n;
    logic              bad_op;
    logic [ADDR_W:0]   last_byte;
    logic              illegal;
    logic [1:0]        cap_idx;

    function automatic logic [2:0] size_of(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: size_of = 3'd1;
            3'b001, 3'b101: size_of = 3'd2;
            3'b010:         size_of = 3'd4;
            default:        size_of = 3'd1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] b);
        case (op)
            3'b000:  extend = {{24{b[7]}}, b[7:0]};
            3'b001:  extend = {{16{b[15]}}, b[15:0]};
            3'b100:  extend = {24'd0, b[7:0]};
            3'b101:  extend = {16'd0, b[15:0]};
            default: extend = b;
        endcase
    endfunction

    // Grant is combinational and only ever offered in IDLE.
    always_comb begin
        gnt      = '0;
        gnt_port = (bus.req_i[0] && bus.req_i[1]) ? rr_ptr_q : bus.req_i[1];
        if (state_q == S_IDLE && (|bus.req_i)) begin
            gnt[gnt_port] = 1'b1;
        end
    end

    always_comb begin
        sel_we    = bus.we_i[gnt_port];
        sel_op    = bus.op_i[gnt_port];
        sel_addr  = bus.addr_i[gnt_port];
        sel_wdata = bus.wdata_i[gnt_port];
        sel_n     = size_of(sel_op);
        bad_op    = (sel_op == 3'b011) || (sel_op == 3'b110) || (sel_op == 3'b111) ||
                    (sel_we && sel_op[2]);
        // One bit wider than the address so the range check never wraps.
        last_byte = {1'b0, sel_addr} + (ADDR_W+1)'(sel_n) - (ADDR_W+1)'(1);
        illegal   = bad_op || (last_byte >= (ADDR_W+1)'(MEM_DEPTH));
        lat_n     = size_of(op_q);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        port_d      = port_q;
        we_d        = we_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cap_idx     = '0;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    port_d   = gnt_port;
                    rr_ptr_d = ~gnt_port;
                    we_d     = sel_we;
                    op_d     = sel_op;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    cnt_d    = 3'd1;
                    rbuf_d   = '0;
                    if (illegal) begin
                        state_d          = S_DONE;
                        done_d[gnt_port] = 1'b1;
                        err_d[gnt_port]  = 1'b1;
                    end else begin
                        // Byte 0 is registered here so it is on the bus in the first ISSUE cycle.
                        state_d     = S_ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata[7:0];
                    end
                end
            end
            S_ISSUE: begin
                // cnt_q counts bytes already on the bus; read data lags the issue by one cycle.
                if (!we_q && cnt_q >= 3'd2) begin
                    cap_idx                      = cnt_q[1:0] - 2'd2;
                    rbuf_d[{cap_idx, 3'b000} +: 8] = mem_rdata_i;
                end
                if (cnt_q < lat_n) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = addr_q + ADDR_W'(cnt_q);
                    mem_wdata_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d       = cnt_q + 3'd1;
                end else if (we_q) begin
                    state_d        = S_DONE;
                    done_d[port_q] = 1'b1;
                end else begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                cap_idx                        = lat_n[1:0] - 2'd1;
                rbuf_d[{cap_idx, 3'b000} +: 8] = mem_rdata_i;
                rdata_d                        = extend(op_q, rbuf_d);
                done_d[port_q]                 = 1'b1;
                state_d                        = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            port_q      <= port_d;
            we_q        <= we_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.gnt_o      = gnt;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.rdata_o[0] = done_q[0] ? rdata_q : '0;
    assign bus.rdata_o[1] = done_q[1] ? rdata_q : '0;
    assign mem_en_o       = mem_en_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
endmodule
